// File: rtl/watch_pkg.sv
// Shared watch types: BCD digit, digit limits and the stopwatch state encoding.
package watch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_UNITS_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX  = 4'd5;
    localparam bcd_t MIN_UNITS_MAX = 4'd9;
    localparam bcd_t MIN_TENS_MAX  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } sw_state_t;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch chain: increments on inc, wraps MAX->0 with a carry.
module bcd_digit_cnt
    import watch_pkg::*;
#(
    parameter bcd_t MAX = SEC_UNITS_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output bcd_t digit,
    output logic carry
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc && (digit_q == MAX);

endmodule

// File: rtl/stopwatch_up.sv
// Count-up MM:SS stopwatch with start/stop, clear and registered BCD display.
// Optional lap freeze of the display is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_up
    import watch_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_stop,
    input  logic clear,
    input  logic lap,
    output bcd_t s1,
    output bcd_t s2,
    output bcd_t s3,
    output bcd_t s4,
    output logic running,
    output logic full,
    output logic lap_held
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    sw_state_t     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd_t [3:0]    disp_q, disp_d;
    bcd_t [3:0]    live;
    logic          running_q, full_q;
    logic          held_q, held_d;
    logic          sec_tick;
    logic          at_max;
    logic          c0, c1, c2, c3;

    assign sec_tick = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign at_max   = (live[3] == MIN_TENS_MAX)  && (live[2] == MIN_UNITS_MAX) &&
                      (live[1] == SEC_TENS_MAX)  && (live[0] == SEC_UNITS_MAX);

    // Saturation is handled here by withholding the tick, so s4 never wraps.
    bcd_digit_cnt #(.MAX(SEC_UNITS_MAX)) u_sec_units (
        .clk(clk), .rst_n(rst_n), .inc(sec_tick && !at_max), .clr(clear),
        .digit(live[0]), .carry(c0)
    );
    bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .inc(c0), .clr(clear),
        .digit(live[1]), .carry(c1)
    );
    bcd_digit_cnt #(.MAX(MIN_UNITS_MAX)) u_min_units (
        .clk(clk), .rst_n(rst_n), .inc(c1), .clr(clear),
        .digit(live[2]), .carry(c2)
    );
    bcd_digit_cnt #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .inc(c2), .clr(clear),
        .digit(live[3]), .carry(c3)
    );

    logic unused_carry;
    assign unused_carry = c3;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_stop) state_d = RUN;
                RUN: begin
                    if (sec_tick && at_max)  state_d = FULL;
                    else if (start_stop)     state_d = PAUSE;
                end
                PAUSE:   if (start_stop) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = sec_tick ? '0 : presc_q + PW'(1);
        end
    end

`ifdef STOPWATCH_LAP_EN
    bcd_t [3:0] hold_q, hold_d;
    logic       lap_ok;

    // Capture uses the pre-update live value, so a same-cycle tick is not seen.
    assign lap_ok = lap && !clear && ((state_q == RUN) || (state_q == PAUSE));

    always_comb begin
        hold_d = hold_q;
        held_d = held_q;
        if (clear) begin
            held_d = 1'b0;
        end else if (lap_ok) begin
            held_d = !held_q;
            if (!held_q) hold_d = live;
        end
        disp_d = clear ? '0 : (held_d ? hold_d : live);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;

    always_comb begin
        held_d = 1'b0;
        disp_d = clear ? '0 : live;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            disp_q    <= '0;
            held_q    <= 1'b0;
            running_q <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            disp_q    <= disp_d;
            held_q    <= held_d;
            running_q <= (state_d == RUN);
            full_q    <= (state_d == FULL);
        end
    end

    assign s1       = disp_q[0];
    assign s2       = disp_q[1];
    assign s3       = disp_q[2];
    assign s4       = disp_q[3];
    assign running  = running_q;
    assign full     = full_q;
    assign lap_held = held_q;

endmodule

// File: doc/stopwatch_up.md
# stopwatch_up

Count-up stopwatch that accumulates elapsed time as four BCD digits (MM:SS, 00:00 to 99:59) from the system clock, with start/stop, clear and lap-freeze controls. It is the count-up counterpart of the team's countdown timer: it drives the same four-digit BCD display bus that the countdown timer consumes, so the display path is shared between watch modes.

## Interface
- `TICKS_PER_SEC`, default 100000000: clk cycles per elapsed second; must be 2 or more.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start_stop`  in  1  single-cycle pulse that toggles run/pause; already debounced and synchronous to clk.
- `clear`  in  1  single-cycle pulse that returns time to 00:00 and stops the watch.
- `lap`  in  1  single-cycle pulse that toggles the display freeze (only with `STOPWATCH_LAP_EN`).
- `s1`  out  4  displayed seconds units, BCD 0–9.
- `s2`  out  4  displayed seconds tens, BCD 0–5.
- `s3`  out  4  displayed minutes units, BCD 0–9.
- `s4`  out  4  displayed minutes tens, BCD 0–9.
- `running`  out  1  high in RUN.
- `full`  out  1  high in FULL (count saturated at 99:59).
- `lap_held`  out  1  high while the display is frozen.

## Operation
- States:
  - IDLE: time 00:00, stopped.
  - RUN: counting.
  - PAUSE: stopped, time nonzero or partial second retained.
  - FULL: saturated at 99:59.
- Transitions:
  - IDLE --start_stop--> RUN.
  - RUN --start_stop--> PAUSE.
  - PAUSE --start_stop--> RUN.
  - RUN reaches 99:59 --> FULL.
  - Any state --clear--> IDLE.
  - FULL ignores start_stop.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in RUN.
  - Asserts an internal sec_tick when it wraps.
  - Holds its value in PAUSE, so a resumed second continues where it stopped.
  - Zeroed by clear.
- Live digit chain:
  - s1 increments on sec_tick and wraps 9→0 with a carry.
  - s2 wraps 5→0 with a carry.
  - s3 wraps 9→0 with a carry.
  - s4 increments up to 9.
- On a sec_tick at 99:59 the live count does not change and the state goes to FULL.
- Lap, in RUN or PAUSE:
  - When not held: copies the live digits into the display hold register and sets lap_held.
  - When held: releases the hold and the display returns to the live digits.
  - The live count keeps running throughout.
- Lap in IDLE or FULL is ignored.
- Clear releases the hold.
- s1..s4 are registered: the displayed value is the hold register when lap_held is high, otherwise the live digits.
- Simultaneous pulses:
  - clear dominates both start_stop and lap.
  - start_stop and lap in the same cycle are both applied; the lap captures the pre-update live value.

## Timing
- Reset values: s1..s4 = 0, running = 0, full = 0, lap_held = 0, state IDLE, prescaler 0.
- start_stop → running changes on the next rising edge (1-cycle latency).
- From entering RUN with the prescaler at 0, the first s1 increment is visible TICKS_PER_SEC cycles plus 1 register stage later.
- A carry ripples across all digits within the same cycle; 09:59 → 10:00 happens in one edge.
- lap → lap_held and the frozen s1..s4 are visible 1 cycle after the pulse.
- clear → all outputs at reset values 1 cycle after the pulse.
- rst_n assertion mid-count forces reset values immediately (asynchronous); release is synchronous-safe upstream.

## Configuration
- `STOPWATCH_LAP_EN` defined: hold register, lap toggling and lap_held are as described above.
- `STOPWATCH_LAP_EN` undefined:
  - No hold register.
  - lap input is ignored.
  - lap_held is tied 0.
  - s1..s4 always show the live digits.

## Structure
- Shared package `watch_pkg`:
  - `bcd_t` (4-bit BCD digit).
  - Digit limits `SEC_UNITS_MAX` = 9, `SEC_TENS_MAX` = 5, `MIN_UNITS_MAX` = 9, `MIN_TENS_MAX` = 9.
  - State enum `sw_state_t` (IDLE, RUN, PAUSE, FULL).
- Sub-module `bcd_digit_cnt`:
  - Parameter MAX.
  - Inputs: inc, clr.
  - Outputs: the digit and a carry, where carry = inc && digit == MAX.
  - Instantiated four times to form the digit chain.

## Test plan
All scenarios use TICKS_PER_SEC = 4.
- Reset, then start_stop: running = 1 on the next edge; s1 = 1 after 4 cycles plus 1; 00:10 after 40 cycles.
- Run from 09:59 (59 s plus 9 min): the next tick gives s4..s1 = 1,0,0,0 in a single edge.
- Pause after 2 prescaler counts, then resume: the next increment comes 2 cycles after resume. Time is unchanged while paused.
- Run to 99:59, then one more tick: full = 1, running = 0, display stays 99:59. A start_stop after that is ignored.
- With `STOPWATCH_LAP_EN`, lap at 00:03 in RUN:
  - Display holds 00:03 while the live count continues.
  - A second lap at live 00:07 shows 00:07 and lap_held = 0.
- clear asserted in the same cycle as start_stop and lap while in RUN: the next edge gives IDLE, 00:00, running = 0 and lap_held = 0.
